// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates N requesters loading a shared W-bit holding
// register through a registered grant/acknowledge handshake, plus a clear path.
// Optional feature macro: REGARB_RR_EN (round-robin arbitration). Without it,
// the arbiter uses fixed priority and the lowest index wins.
module reg_write_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           r,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           clr,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StAck   = 2'd2;
  localparam logic [1:0] StClear = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] win_q, win_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [W-1:0]  wslice [N];

  // Unpack the flat data bus into per-requester slices.
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign wslice[i] = wdata[i*W +: W];
  end

`ifdef REGARB_RR_EN
  logic [IW-1:0] p_q, p_d;

  // Round-robin pick: first active request scanning p, p+1, ... with wrap.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cand;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = k + {{(32-IW){1'b0}}, p_q};
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest active index wins.
  always_comb begin
    logic [IW-1:0] cand;
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'(k);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end
`endif

  // Next-state logic for the handshake sequencer; gnt/ack are one-cycle pulses.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    q_d     = q_q;
    gnt_d   = '0;
    ack_d   = '0;
`ifdef REGARB_RR_EN
    p_d     = p_q;
`endif
    case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
        end else if (sel_vld) begin
          state_d = StGrant;
          win_d   = sel;
          gnt_d   = One << sel;
        end
      end
      StGrant: begin
        // Commit regardless of whether the requester dropped req meanwhile.
        q_d     = wslice[win_q];
        ack_d   = One << win_q;
        state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
`ifdef REGARB_RR_EN
        p_d     = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
`endif
      end
      StClear: begin
        q_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= StIdle;
      win_q   <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
`ifdef REGARB_RR_EN
      p_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
`ifdef REGARB_RR_EN
      p_q     <= p_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign q    = q_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: table of single writes, a
// contention run, and hand sequences for reset, clear priority and abort.
module tb_reg_write_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           r;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
  } exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  reg_write_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .r     (r),
    .req   (req),
    .wdata (wdata),
    .clr   (clr),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: grants compared against the head entry, acks pop it.
  always @(negedge clk) begin
    exp_t e;
    if (!r) begin
      check("gnt_ack_exclusive", 32'(gnt != '0 && ack != '0), 32'd0);
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      check("ack_onehot", 32'($onehot0(ack)), 32'd1);
      if (gnt != '0 && sb.size() > 0) check("gnt", 32'(gnt), 32'(sb[0].gnt));
      if (ack != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %0h expected 0", ack);
        end else begin
          e = sb.pop_front();
          check("ack", 32'(ack), 32'(e.gnt));
          check("q_at_ack", 32'(q), 32'(e.q));
        end
      end
    end
  end

  task automatic wait_sb(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    e.gnt = v.gnt;
    e.q   = v.q;
    sb.push_back(e);
    req   = v.req;
    wdata = v.wdata;
    wait_sb(10);
    req = '0;
    check({name, "_q"}, 32'(q), 32'(v.q));
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   idx;
    vecs[0] = '{4'b0010, 32'hEEEE11EE, 4'b0010, 8'h11};
    vecs[1] = '{4'b0001, 32'hEEEEEEA5, 4'b0001, 8'hA5};
    vecs[2] = '{4'b1000, 32'h5AEEEEEE, 4'b1000, 8'h5A};
    vecs[3] = '{4'b0110, 32'hEE3CC3EE, 4'b0010, 8'hC3};
    vecs[4] = '{4'b0011, 32'hEEEEF00F, 4'b0001, 8'h0F};
    vecs[5] = '{4'b1100, 32'h8877EEEE, 4'b0100, 8'h77};
`ifdef REGARB_RR_EN
    vecs[6] = '{4'b1001, 32'h80EEEE01, 4'b1000, 8'h80};
    vecs[7] = '{4'b1001, 32'h80EEEE01, 4'b0001, 8'h01};
    vecs[8] = '{4'b1001, 32'h80EEEE01, 4'b1000, 8'h80};
`else
    vecs[6] = '{4'b1001, 32'h80EEEE01, 4'b0001, 8'h01};
    vecs[7] = '{4'b1001, 32'h80EEEE01, 4'b0001, 8'h01};
    vecs[8] = '{4'b1001, 32'h80EEEE01, 4'b0001, 8'h01};
`endif

    // Reset held two edges with everything requesting.
    r     = 1'b1;
    req   = '1;
    clr   = 1'b1;
    wdata = 32'h44332211;
    repeat (2) @(posedge clk);
    #2;
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    r = 1'b0;
    @(posedge clk);
    #2;
    check("post_rst_clear_busy", 32'(busy), 32'd1);
    check("post_rst_clear_gnt", 32'(gnt), 32'd0);
    clr = 1'b0;
    req = '0;
    @(posedge clk);
    #2;
    check("post_clear_busy", 32'(busy), 32'd0);
    check("post_clear_q", 32'(q), 32'd0);

    // Table of single transactions, including wrap-around of the pointer.
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention: all four requesting continuously.
    wdata = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
`ifdef REGARB_RR_EN
      idx = k % 4;
`else
      idx = 0;
`endif
      e.gnt = 4'b0001 << idx;
      e.q   = 8'h11 * 8'(idx + 1);
      sb.push_back(e);
    end
    req = 4'b1111;
    wait_sb(30);
    req = '0;
    check("contention_busy", 32'(busy), 32'd0);

    // Clear wins over a simultaneous request.
    run_vec('{4'b0001, 32'hEEEEEE11, 4'b0001, 8'h11}, "pre_clr");
    e.gnt = 4'b0100;
    e.q   = 8'h33;
    sb.push_back(e);
    clr   = 1'b1;
    req   = 4'b0100;
    wdata = 32'hEE33EEEE;
    @(posedge clk);
    #2;
    check("clr_state_busy", 32'(busy), 32'd1);
    check("clr_state_gnt", 32'(gnt), 32'd0);
    check("clr_state_q", 32'(q), 32'h11);
    clr = 1'b0;
    @(posedge clk);
    #2;
    check("clr_done_q", 32'(q), 32'd0);
    check("clr_done_busy", 32'(busy), 32'd0);
    wait_sb(10);
    req = '0;
    check("clr_then_write_q", 32'(q), 32'h33);

    // Reset in the middle of a grant aborts the write.
    run_vec('{4'b0001, 32'hEEEEEE11, 4'b0001, 8'h11}, "pre_abort");
    req   = 4'b0100;
    wdata = 32'hEE33EEEE;
    @(posedge clk);
    #2;
    check("abort_gnt", 32'(gnt), 32'b0100);
    r   = 1'b1;
    req = '0;
    @(posedge clk);
    #2;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_gnt_clr", 32'(gnt), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    r = 1'b0;
    // Pointer back at 0: requester 0 wins over 3.
    run_vec('{4'b1001, 32'h80EEEE01, 4'b0001, 8'h01}, "post_abort");

    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
